// File: rtl/cram_loader.sv
// Master-side driver for a CRAM configuration shift chain: serialises bitstream
// words into the chain (load) or shifts it out non-destructively into words (readback).
module cram_loader #(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CHAIN_LEN = 384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              rb_start,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              cfg_en,
  output logic              cfg_sdo,
  input  logic              cfg_sdi,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned OCC_W  = $clog2(WORD_W + 1);
  localparam int unsigned DCNT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    READBACK = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   shreg;
  logic [OCC_W-1:0]    occ;
  logic [CNT_W-1:0]    bit_cnt;
  logic [WORD_W-2:0]   deser;
  logic [DCNT_W-1:0]   dcnt;
  logic [WORD_W-1:0]   deser_full;
  logic [DCNT_W-1:0]   shamt;
  logic                last_bit;
  logic                cap_last;

  assign last_bit   = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign cap_last   = (dcnt == DCNT_W'(WORD_W - 1)) || last_bit;
  assign deser_full = {deser, cfg_sdi};
  // A short final readback word is left-aligned so its first bit lands in the MSB.
  assign shamt      = DCNT_W'(WORD_W - 1) - dcnt;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the chain-facing handshake and shift controls.
  always_comb begin
    state_nxt = state;
    cfg_en    = 1'b0;
    cfg_sdo   = 1'b0;
    wr_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (load_start)    state_nxt = LOAD;
        else if (rb_start) state_nxt = READBACK;
      end
      LOAD: begin
        cfg_en   = (occ != '0);
        cfg_sdo  = shreg[WORD_W-1];
        wr_ready = (occ == '0) || ((occ == OCC_W'(1)) && cfg_en);
        if (cfg_en && last_bit) state_nxt = IDLE;
      end
      READBACK: begin
        cfg_sdo = cfg_sdi;
        // Stall the chain rather than drop a word when the output register is still full.
        cfg_en  = !(cap_last && rd_valid && !rd_ready);
        if (cfg_en && last_bit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      occ      <= '0;
      bit_cnt  <= '0;
      deser    <= '0;
      dcnt     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (rd_valid && rd_ready) rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (state_nxt != IDLE) begin
            shreg   <= '0;
            occ     <= '0;
            bit_cnt <= '0;
            deser   <= '0;
            dcnt    <= '0;
          end
        end
        LOAD: begin
          if (cfg_en) begin
            shreg   <= {shreg[WORD_W-2:0], 1'b0};
            occ     <= occ - OCC_W'(1);
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
          if (wr_valid && wr_ready) begin
            shreg <= wr_data;
            occ   <= OCC_W'(WORD_W);
          end
          // Leftover bits of the final word are dropped.
          if (cfg_en && last_bit) begin
            shreg <= '0;
            occ   <= '0;
            done  <= 1'b1;
          end
        end
        READBACK: begin
          if (cfg_en) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (cap_last) begin
              rd_data  <= deser_full << shamt;
              rd_valid <= 1'b1;
              deser    <= '0;
              dcnt     <= '0;
            end else begin
              deser <= deser_full[WORD_W-2:0];
              dcnt  <= dcnt + DCNT_W'(1);
            end
            if (last_bit) done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cram_loader.sv
// Bench for cram_loader: chain model, directed plan steps and randomized load/readback
// rounds checked against an arithmetic bit-order reference.
module tb_cram_loader;

  localparam int unsigned WORD_W    = 8;
  localparam int unsigned CHAIN_LEN = 20;
  localparam int unsigned NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_start = 1'b0;
  logic              rb_start = 1'b0;
  logic [WORD_W-1:0] wr_data = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic              cfg_en;
  logic              cfg_sdo;
  logic              cfg_sdi;
  logic              busy;
  logic              done;

  int checks = 0;
  int failures = 0;

  logic [CHAIN_LEN-1:0] chain = '0;
  int                   nshift = 0;
  int                   cyc = 0;
  int                   done_cnt = 0;
  int                   rd_total = 0;
  int                   shift_cyc [4096];
  logic [WORD_W-1:0]    rd_log [256];
  logic [WORD_W-1:0]    cur_words [NWORDS];

  cram_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .rb_start(rb_start),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .cfg_en(cfg_en), .cfg_sdo(cfg_sdo), .cfg_sdi(cfg_sdi),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Chain model: head at index 0, tail at index CHAIN_LEN-1; it has no link to rst.
  assign cfg_sdi = chain[CHAIN_LEN-1];
  always @(posedge clk) if (cfg_en) chain <= {chain[CHAIN_LEN-2:0], cfg_sdo};

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cfg_en) begin
      shift_cyc[nshift % 4096] = cyc;
      nshift = nshift + 1;
    end
    if (done) done_cnt = done_cnt + 1;
    if (rd_valid && rd_ready) begin
      rd_log[rd_total % 256] = rd_data;
      rd_total = rd_total + 1;
    end
  end

  // k-th transmitted bit is word k/W, bit W-1-(k mod W); it settles at index CHAIN_LEN-1-k.
  function automatic logic [CHAIN_LEN-1:0] ref_chain();
    logic [CHAIN_LEN-1:0] r;
    logic [WORD_W-1:0]    w;
    r = '0;
    for (int k = 0; k < int'(CHAIN_LEN); k++) begin
      w = cur_words[k / int'(WORD_W)];
      r[int'(CHAIN_LEN) - 1 - k] = w[int'(WORD_W) - 1 - (k % int'(WORD_W))];
    end
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] ref_rd_word(input int j);
    int                used;
    logic [WORD_W-1:0] m;
    used = int'(CHAIN_LEN) - j * int'(WORD_W);
    if (used > int'(WORD_W)) used = int'(WORD_W);
    m = '0;
    for (int b = 0; b < used; b++) m[int'(WORD_W) - 1 - b] = 1'b1;
    return cur_words[j] & m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_load(input int gap, input bit rb_mid, input bit both_start);
    int sbase, dbase;
    bit acc;
    @(negedge clk);
    load_start = 1'b1;
    rb_start   = both_start;
    @(negedge clk);
    load_start = 1'b0;
    rb_start   = 1'b0;
    sbase = nshift;
    dbase = done_cnt;
    if (both_start) begin
      #1;
      check("prio_wr_ready", 32'(wr_ready), 32'd1);
      check("prio_cfg_en", 32'(cfg_en), 32'd0);
    end
    for (int j = 0; j < int'(NWORDS); j++) begin
      wr_data  = cur_words[j];
      wr_valid = 1'b1;
      if (rb_mid && j == 1) rb_start = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        #1;
        acc = wr_ready;
        @(negedge clk);
        rb_start = 1'b0;
      end
      if (!acc) check("load_accept_timeout", 32'd0, 32'd1);
      if (j < int'(NWORDS) - 1 && gap > 0) begin
        wr_valid = 1'b0;
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
          #1;
          acc = wr_ready;
          if (!acc) @(negedge clk);
        end
        repeat (gap) @(negedge clk);
      end
    end
    wr_valid = 1'b0;
    acc = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      #1;
      acc = !busy;
    end
    if (!acc) check("load_busy_timeout", 32'd0, 32'd1);
    check("load_done_high", 32'(done), 32'd1);
    check("load_shifts", 32'(nshift - sbase), 32'(CHAIN_LEN));
    check("load_chain", 32'(chain), 32'(ref_chain()));
    if (gap == 0)
      check("load_gap_free",
            32'(shift_cyc[(sbase + int'(CHAIN_LEN) - 1) % 4096] - shift_cyc[sbase % 4096]),
            32'(CHAIN_LEN - 1));
    @(negedge clk);
    #1;
    check("load_done_once", 32'(done_cnt - dbase), 32'd1);
    check("load_done_low", 32'(done), 32'd0);
  endtask

  // mode 0: rd_ready held high, 1: random rd_ready, 2: 10-cycle backpressure after first word
  task automatic run_rb(input int mode);
    int sbase, dbase, rbase;
    logic [CHAIN_LEN-1:0] saved;
    bit ok;
    saved = chain;
    sbase = nshift;
    dbase = done_cnt;
    rbase = rd_total;
    @(negedge clk);
    rb_start = 1'b1;
    rd_ready = (mode == 0);
    @(negedge clk);
    rb_start = 1'b0;
    if (mode == 2) begin
      ok = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
        #1;
        ok = rd_valid;
        if (!ok) @(negedge clk);
      end
      if (!ok) check("rb_first_valid_timeout", 32'd0, 32'd1);
      check("rb_bp_first_word", 32'(rd_data), 32'(cur_words[0]));
      check("rb_bp_first_shifts", 32'(nshift - sbase), 32'(WORD_W));
      repeat (10) @(negedge clk);
      #1;
      check("rb_bp_stalled_shifts", 32'(nshift - sbase), 32'(2 * WORD_W - 1));
      check("rb_bp_cfg_en", 32'(cfg_en), 32'd0);
      check("rb_bp_hold_data", 32'(rd_data), 32'(cur_words[0]));
      check("rb_bp_hold_valid", 32'(rd_valid), 32'd1);
      rd_ready = 1'b1;
    end
    ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      #1;
      ok = !busy && !rd_valid;
      if (mode == 1) rd_ready = 1'($urandom_range(0, 1));
    end
    if (!ok) check("rb_finish_timeout", 32'd0, 32'd1);
    @(negedge clk);
    rd_ready = 1'b0;
    check("rb_word_count", 32'(rd_total - rbase), 32'(NWORDS));
    for (int j = 0; j < int'(NWORDS); j++)
      check($sformatf("rb_word%0d", j), 32'(rd_log[(rbase + j) % 256]), 32'(ref_rd_word(j)));
    check("rb_chain_kept", 32'(chain), 32'(saved));
    check("rb_shifts", 32'(nshift - sbase), 32'(CHAIN_LEN));
    check("rb_done_once", 32'(done_cnt - dbase), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int sbase;
    bit ok;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_cfg_en", 32'(cfg_en), 32'd0);
    check("rst_cfg_sdo", 32'(cfg_sdo), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed data from the plan, gap-free then with stalls.
    cur_words[0] = 8'hA5;
    cur_words[1] = 8'h3C;
    cur_words[2] = 8'hF0;
    run_load(0, 1'b0, 1'b0);
    check("plan_chain_literal", 32'(chain), 32'hA53CF);
    run_load(3, 1'b0, 1'b0);
    check("plan_chain_literal_gaps", 32'(chain), 32'hA53CF);
    run_rb(0);
    run_rb(2);

    // Start priority and rb_start ignored mid-load.
    for (int j = 0; j < int'(NWORDS); j++) cur_words[j] = 8'($urandom_range(0, 255));
    run_load(1, 1'b1, 1'b1);
    run_rb(0);

    // Asynchronous reset partway through a load.
    for (int j = 0; j < int'(NWORDS); j++) cur_words[j] = 8'($urandom_range(0, 255));
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    sbase = nshift;
    wr_data  = cur_words[0];
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = (nshift - sbase) >= 7;
    end
    check("rst_mid_shifts", 32'(nshift - sbase), 32'd7);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_cfg_en", 32'(cfg_en), 32'd0);
    check("rst_mid_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_no_extra", 32'(nshift - sbase), 32'd7);
    for (int j = 0; j < int'(NWORDS); j++) cur_words[j] = 8'($urandom_range(0, 255));
    run_load(0, 1'b0, 1'b0);

    // Randomized rounds: random data, random word gaps, random read backpressure.
    for (int r = 0; r < 10; r++) begin
      for (int j = 0; j < int'(NWORDS); j++) cur_words[j] = 8'($urandom_range(0, 255));
      run_load(int'($urandom_range(0, 3)), 1'b0, 1'b0);
      run_rb(int'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
